rv_plic_claim_host: RTL

TL-UL host that services one PLIC interrupt target on behalf of a hart. When the PLIC target's `irq_o` is asserted, it:

- reads the claim/complete (CC) register to claim the highest-priority ID;
- hands that ID to the core over a valid/ready handshake;
- waits for the core's service-done pulse;
- writes the ID back to CC to complete.

It sits between the hart and the PLIC register bus, one instance per target.

---
 rtl/tlul_pkg.sv | 36 +++
 rtl/rv_plic_claim_host.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the PLIC register bus and its hosts.
// Field widths follow a 32-bit data bus with 8-bit source IDs.
package tlul_pkg;

  localparam logic [2:0] OP_PUT_FULL_DATA = 3'h0;
  localparam logic [2:0] OP_GET           = 3'h4;

  // Host to device: A channel plus D-channel ready.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  // Device to host: D channel plus A-channel ready.
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/rv_plic_claim_host.sv
// rv_plic_claim_host: TL-UL host servicing one PLIC target for a hart.
// Claims the pending ID from the CC register, hands it to the core,
// waits for service-done, then writes the ID back to complete.
// Optional feature macro: PLIC_CLAIM_TIMEOUT_EN (per-phase TL-UL timeout).
module rv_plic_claim_host #(
  parameter int unsigned SRCW      = 6,
  parameter logic [31:0] CC_ADDR   = 32'h0C20_0004,
  parameter logic [7:0]  SOURCE_ID = 8'd0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                irq_i,
  output tlul_pkg::tl_h2d_t   tl_o,
  input  tlul_pkg::tl_d2h_t   tl_i,
  output logic                id_valid_o,
  output logic [SRCW-1:0]     id_o,
  input  logic                id_ready_i,
  input  logic                done_i,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM_REQ,
    S_CLAIM_RSP,
    S_DELIVER,
    S_SERVICE,
    S_CMPL_REQ,
    S_CMPL_RSP
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SRCW-1:0]   r_id;
  logic [SRCW-1:0]   w_id_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_timeout;

  // Bits of the D channel this host never looks at.
  logic w_unused_tl;
  assign w_unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_data[31:SRCW], tl_i.d_user};

`ifdef PLIC_CLAIM_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  // The counter value is the number of cycles already spent in the state,
  // so the TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_timed;

  assign w_timed = (r_state == S_CLAIM_REQ) || (r_state == S_CLAIM_RSP) ||
                   (r_state == S_CMPL_REQ)  || (r_state == S_CMPL_RSP);
  assign w_timeout = w_timed && (r_cnt == CNT_LAST);

  // Phase cycle counter: restarts on every state change, runs only in bus states.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) || !w_timed) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = TIMEOUT[0];
  assign w_timeout    = 1'b0;
`endif

  // State, latched ID and error pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every register samples the
      // pre-edge values; blocking = here would create ordering races.
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; a completed handshake wins over a same-cycle timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (irq_i) w_state_nxt = S_CLAIM_REQ;
      end
      S_CLAIM_REQ: begin
        if (tl_i.a_ready) begin
          w_state_nxt = S_CLAIM_RSP;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CLAIM_RSP: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (tl_i.d_data[SRCW-1:0] == '0) begin
            // ID 0 means nothing was pending: no delivery, no complete.
            w_state_nxt = S_IDLE;
          end else begin
            w_id_nxt    = tl_i.d_data[SRCW-1:0];
            w_state_nxt = S_DELIVER;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DELIVER: begin
        // done_i in the same cycle as id_ready_i is deliberately ignored.
        if (id_ready_i) w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        if (done_i) w_state_nxt = S_CMPL_REQ;
      end
      S_CMPL_REQ: begin
        if (tl_i.a_ready) begin
          w_state_nxt = S_CMPL_RSP;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CMPL_RSP: begin
        if (tl_i.d_valid) begin
          w_err_nxt   = tl_i.d_error;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the state register; A fields only change on a
  // state change, so they are stable for the whole request.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (r_state == S_CLAIM_REQ) || (r_state == S_CMPL_REQ);
    tl_o.a_opcode  = (r_state == S_CMPL_REQ) ? tlul_pkg::OP_PUT_FULL_DATA
                                             : tlul_pkg::OP_GET;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SOURCE_ID;
    tl_o.a_address = CC_ADDR;
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = (r_state == S_CMPL_REQ) ? 32'(r_id) : 32'h0;
    tl_o.d_ready   = (r_state == S_CLAIM_RSP) || (r_state == S_CMPL_RSP);
  end

  assign id_valid_o = (r_state == S_DELIVER);
  assign id_o       = r_id;
  assign busy_o     = (r_state != S_IDLE);
  assign err_o      = r_err;

endmodule
